// File: rtl/inst_queue_decode.sv
// ---------------------------------------------------------------------------
// inst_queue_decode
//   Instruction queue with pre-decode for the ONC-16 core. Instructions are
//   classified and field-extracted when pushed, held in a circular buffer of
//   DEPTH entries, and presented from the head entry. A synchronous flush
//   empties the queue.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready push handshake; in_ready = (count != DEPTH)
//   in_inst, in_pc    instruction word and its PC
//   flush             discard all entries at the next edge (wins over push/pop)
//   out_valid/ready   pop handshake; out_valid = (count != 0)
//   out_inst, out_pc  raw head instruction and PC
//   out_class         0 ALU_R, 1 ALU_I, 2 BRANCH, 3 ILLEGAL
//   out_rd/rs/imm     decoded register and immediate fields
//   out_br_cond/reg   branch condition and register-target flag
//   count             current occupancy
// All out_* data fields read 0 while out_valid is low.
// ---------------------------------------------------------------------------
module inst_queue_decode #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_inst,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_inst,
    output logic [PC_W-1:0]          out_pc,
    output logic [1:0]               out_class,
    output logic [3:0]               out_rd,
    output logic [3:0]               out_rs,
    output logic [7:0]               out_imm,
    output logic [2:0]               out_br_cond,
    output logic                     out_br_reg,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        CLS_ALU_R   = 2'd0,
        CLS_ALU_I   = 2'd1,
        CLS_BRANCH  = 2'd2,
        CLS_ILLEGAL = 2'd3
    } cls_e;

    typedef struct packed {
        logic [15:0]     inst;
        logic [PC_W-1:0] pc;
        cls_e            cls;
        logic [3:0]      rd;
        logic [3:0]      rs;
        logic [7:0]      imm;
        logic [2:0]      br_cond;
        logic            br_reg;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          dec_d;
    entry_t          head;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    // Pre-decode of the incoming word; every field not owned by the class
    // stays at its zero default.
    always_comb begin
        dec_d      = '0;
        dec_d.inst = in_inst;
        dec_d.pc   = in_pc;
        dec_d.cls  = CLS_ILLEGAL;
        unique case (in_inst[15:12])
            4'h0: begin
                if (in_inst[11:8] != 4'h0 && in_inst[11:8] != 4'h6 &&
                    in_inst[11:8] != 4'hF) begin
                    dec_d.cls = CLS_ALU_R;
                    dec_d.rd  = in_inst[7:4];
                    dec_d.rs  = in_inst[3:0];
                end
            end
            4'h3, 4'h7: dec_d.cls = CLS_ILLEGAL;
            4'hF: begin
                dec_d.cls     = CLS_BRANCH;
                dec_d.br_cond = in_inst[10:8];
                dec_d.br_reg  = in_inst[11];
                if (in_inst[11]) dec_d.rs  = in_inst[3:0];
                else             dec_d.imm = in_inst[7:0];
            end
            default: begin
                dec_d.cls = CLS_ALU_I;
                dec_d.rd  = in_inst[11:8];
                dec_d.imm = in_inst[7:0];
            end
        endcase
    end

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible unless count covers it.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q] <= dec_d;
    end

    always_comb begin
        head = '0;
        if (out_valid) head = mem_q[rptr_q];
    end

    assign out_inst    = head.inst;
    assign out_pc      = head.pc;
    assign out_class   = head.cls;
    assign out_rd      = head.rd;
    assign out_rs      = head.rs;
    assign out_imm     = head.imm;
    assign out_br_cond = head.br_cond;
    assign out_br_reg  = head.br_reg;
    assign count       = count_q;

endmodule

// File: tb/tb_inst_queue_decode.sv
module tb_inst_queue_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_inst;
    logic [15:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic [1:0]  out_class;
    logic [3:0]  out_rd;
    logic [3:0]  out_rs;
    logic [7:0]  out_imm;
    logic [2:0]  out_br_cond;
    logic        out_br_reg;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_queue_decode #(.DEPTH(4), .PC_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_class(out_class),
        .out_rd(out_rd), .out_rs(out_rs), .out_imm(out_imm),
        .out_br_cond(out_br_cond), .out_br_reg(out_br_reg),
        .count(count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 0; in_inst = '0; in_pc = '0;
        flush = 0; out_ready = 0;
        #12;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: count=%0d out_valid=%b in_ready=%b, want 0 0 1",
                     count, out_valid, in_ready);
        end
        checks++;
        if ({out_inst, out_pc, out_class, out_rd, out_rs, out_imm, out_br_cond, out_br_reg} !== '0) begin
            errors++;
            $display("FAIL reset_data: inst=%h pc=%h class=%0d, want all zero",
                     out_inst, out_pc, out_class);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_r;
        in_inst = 16'h0187; in_pc = 16'h0010; in_valid = 1;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || count !== 3'd1) begin
            errors++;
            $display("FAIL alu_r_valid: out_valid=%b count=%0d, want 1 1", out_valid, count);
        end
        checks++;
        if (out_class !== 2'd0 || out_rd !== 4'h8 || out_rs !== 4'h7 || out_imm !== 8'h00 ||
            out_pc !== 16'h0010 || out_inst !== 16'h0187) begin
            errors++;
            $display("FAIL alu_r_fields: class=%0d rd=%h rs=%h imm=%h pc=%h inst=%h, want 0 8 7 00 0010 0187",
                     out_class, out_rd, out_rs, out_imm, out_pc, out_inst);
        end
        tick();
        checks++;
        if (out_inst !== 16'h0187) begin
            errors++;
            $display("FAIL alu_r_hold: inst=%h, want 0187", out_inst);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_r_pop: count=%0d out_valid=%b, want 0 0", count, out_valid);
        end
    endtask

    task automatic test_classes;
        // {inst, class, rd, rs, imm, cond, breg}
        logic [15:0] vi [6] = '{16'h1F07, 16'hF807, 16'hF107, 16'h3F07, 16'hFE45, 16'h0A34};
        logic [1:0]  vc [6] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd2, 2'd0};
        logic [3:0]  vd [6] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3};
        logic [3:0]  vs [6] = '{4'h0, 4'h7, 4'h0, 4'h0, 4'h5, 4'h4};
        logic [7:0]  vm [6] = '{8'h07, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        logic [2:0]  vb [6] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd6, 3'd0};
        logic        vr [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            in_inst = vi[i]; in_pc = 16'h0200 + 16'(i); in_valid = 1;
            tick();
            checks++;
            if (out_valid !== 1'b1 || count !== 3'd1 || out_inst !== vi[i] ||
                out_pc !== 16'h0200 + 16'(i)) begin
                errors++;
                $display("FAIL class_head[%0d]: valid=%b count=%0d inst=%h pc=%h, want 1 1 %h %h",
                         i, out_valid, count, out_inst, out_pc, vi[i], 16'h0200 + 16'(i));
            end
            checks++;
            if (out_class !== vc[i] || out_rd !== vd[i] || out_rs !== vs[i] ||
                out_imm !== vm[i] || out_br_cond !== vb[i] || out_br_reg !== vr[i]) begin
                errors++;
                $display("FAIL class_fields[%0d]: cls=%0d rd=%h rs=%h imm=%h cond=%0d breg=%b, want %0d %h %h %h %0d %b",
                         i, out_class, out_rd, out_rs, out_imm, out_br_cond, out_br_reg,
                         vc[i], vd[i], vs[i], vm[i], vb[i], vr[i]);
            end
        end
        in_valid = 0;
        tick();
        out_ready = 0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL class_drain: count=%0d out_valid=%b, want 0 0", count, out_valid);
        end
    endtask

    task automatic test_full;
        logic [15:0] w [5] = '{16'h5101, 16'h5202, 16'h5303, 16'h5404, 16'h5505};
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_inst = w[i]; in_pc = 16'h0100 + 16'(i); in_valid = 1;
            tick();
            checks++;
            if (count !== 3'(i + 1)) begin
                errors++;
                $display("FAIL full_count[%0d]: count=%0d, want %0d", i, count, i + 1);
            end
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: in_ready=%b, want 0", in_ready);
        end
        in_inst = w[4]; in_pc = 16'h0104;
        tick();
        checks++;
        if (count !== 3'd4 || out_inst !== w[0]) begin
            errors++;
            $display("FAIL full_reject: count=%0d head=%h, want 4 %h", count, out_inst, w[0]);
        end
        in_valid = 0; out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_no_bypass: in_ready=%b, want 0", in_ready);
        end
        tick();
        out_ready = 0;
        checks++;
        if (in_ready !== 1'b1 || count !== 3'd3 || out_inst !== w[1] || out_pc !== 16'h0101) begin
            errors++;
            $display("FAIL full_pop: in_ready=%b count=%0d head=%h pc=%h, want 1 3 %h 0101",
                     in_ready, count, out_inst, out_pc, w[1]);
        end
        in_inst = w[4]; in_pc = 16'h0104; in_valid = 1;
        tick();
        in_valid = 0;
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL full_refill: count=%0d, want 4", count);
        end
        out_ready = 1;
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (out_inst !== w[k] || out_pc !== 16'h0100 + 16'(k)) begin
                errors++;
                $display("FAIL wrap_order[%0d]: inst=%h pc=%h, want %h %h",
                         k, out_inst, out_pc, w[k], 16'h0100 + 16'(k));
            end
            tick();
        end
        out_ready = 0;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_drain: count=%0d, want 0", count);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 0; in_valid = 1;
        in_inst = 16'h1000; in_pc = 16'h0000; tick();
        in_inst = 16'h1001; in_pc = 16'h0001; tick();
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_inst = 16'h1002 + 16'(i); in_pc = 16'h0002 + 16'(i);
            checks++;
            if (out_inst !== 16'h1000 + 16'(i) || out_imm !== 8'(i)) begin
                errors++;
                $display("FAIL b2b_head[%0d]: inst=%h imm=%h, want %h %h",
                         i, out_inst, out_imm, 16'h1000 + 16'(i), 8'(i));
            end
            tick();
            checks++;
            if (count !== 3'd2) begin
                errors++;
                $display("FAIL b2b_count[%0d]: count=%0d, want 2", i, count);
            end
        end
        in_valid = 0;
        for (int i = 10; i < 12; i++) begin
            checks++;
            if (out_inst !== 16'h1000 + 16'(i)) begin
                errors++;
                $display("FAIL b2b_tail[%0d]: inst=%h, want %h", i, out_inst, 16'h1000 + 16'(i));
            end
            tick();
        end
        out_ready = 0;
    endtask

    task automatic test_flush;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_inst = 16'h2001 + 16'(i); in_pc = 16'h0300 + 16'(i);
            tick();
        end
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre: count=%0d, want 3", count);
        end
        flush = 1; in_inst = 16'hF999; in_pc = 16'h0999; out_ready = 1;
        tick();
        flush = 0; in_valid = 0; out_ready = 0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_inst !== 16'h0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: count=%0d valid=%b inst=%h ready=%b, want 0 0 0000 1",
                     count, out_valid, out_inst, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_ghost: out_valid=%b inst=%h, want 0", out_valid, out_inst);
        end
        in_inst = 16'h2444; in_pc = 16'h0044; in_valid = 1;
        tick();
        in_valid = 0;
        checks++;
        if (out_inst !== 16'h2444 || out_pc !== 16'h0044 || count !== 3'd1) begin
            errors++;
            $display("FAIL flush_restart: inst=%h pc=%h count=%0d, want 2444 0044 1",
                     out_inst, out_pc, count);
        end
        out_ready = 1; tick(); out_ready = 0;
    endtask

    task automatic test_reset_mid;
        in_valid = 1;
        in_inst = 16'h4011; in_pc = 16'h0011; tick();
        in_inst = 16'h4022; in_pc = 16'h0022; tick();
        in_valid = 0;
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_pre: count=%0d, want 2", count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_inst !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b count=%0d inst=%h, want 0 0 0000",
                     out_valid, count, out_inst);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: count=%0d ready=%b valid=%b, want 0 1 0",
                     count, in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu_r();
        test_classes();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
